// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and read-select encoding for the write-back register file.
package wb_regfile_pkg;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;

   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic                  ReadEnable   = 1'b1;
   localparam logic                  ReadDisable  = 1'b0;

   typedef enum logic [1:0] {
      SelZero   = 2'd0,
      SelBypass = 2'd1,
      SelArray  = 2'd2
   } rdSel_e;

endpackage

// File: rtl/wb_regfile_rd_port.sv
// One decode-stage read port: zero, enable, write-back bypass, then stored entry.
module regfile_rd_port
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus
) (
   input  logic              rst,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] entryData,
   output logic [DATA_W-1:0] rdata
);

   rdSel_e rdSel;

   // The bypass only fires when the write-back result targets this very address,
   // so an instruction in ID sees a result that is still one edge away from storage.
   always_comb begin
      rdSel = SelArray;
      if (!rst) begin
         rdSel = SelZero;
      end else if (raddr == ADDR_W'(NOPRegAddr)) begin
         rdSel = SelZero;
      end else if (re == ReadDisable) begin
         rdSel = SelZero;
      end else if ((we != WriteDisable) && (waddr == raddr)) begin
         rdSel = SelBypass;
      end
   end

   always_comb begin
      rdata = DATA_W'(ZeroWord);
      case (rdSel)
         SelBypass: rdata = wdata;
         SelArray:  rdata = entryData;
         default:   rdata = DATA_W'(ZeroWord);
      endcase
   end

endmodule

// File: rtl/wb_regfile.sv
// Architectural register file fed by MEM/WB, with two bypassed read ports for decode.
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = RegBus,
   parameter int ADDR_W = RegAddrBus,
   parameter int NREG   = RegNum
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re1,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [DATA_W-1:0] rdata1,
   input  logic              re2,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [DATA_W-1:0] rdata2
);

   // $0 is hard-wired, so storage starts at index 1.
   logic [DATA_W-1:0] regs_q [1:NREG-1];
   logic [DATA_W-1:0] regs_d [1:NREG-1];
   logic [DATA_W-1:0] arrData1;
   logic [DATA_W-1:0] arrData2;

   always_comb begin
      regs_d = regs_q;
      if ((we == WriteEnable) && (waddr != ADDR_W'(NOPRegAddr)) && (int'(waddr) < NREG)) begin
         regs_d[waddr] = wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i < NREG; i++) begin
            regs_q[i] <= DATA_W'(ZeroWord);
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      arrData1 = DATA_W'(ZeroWord);
      arrData2 = DATA_W'(ZeroWord);
      if ((raddr1 != '0) && (int'(raddr1) < NREG)) begin
         arrData1 = regs_q[raddr1];
      end
      if ((raddr2 != '0) && (int'(raddr2) < NREG)) begin
         arrData2 = regs_q[raddr2];
      end
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdPort1 (
      .rst       (rst),
      .re        (re1),
      .raddr     (raddr1),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .entryData (arrData1),
      .rdata     (rdata1)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rdPort2 (
      .rst       (rst),
      .re        (re2),
      .raddr     (raddr2),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .entryData (arrData2),
      .rdata     (rdata2)
   );

endmodule
